// File: rtl/obuf_drain.sv
// Output-drain stage: snapshots the array column sums, pulses the accumulator clear,
// then streams requantized columns. Optional ReLU clamp via `OBUF_DRAIN_RELU_EN.
module obuf_requant #(
  parameter int DATA_W = 32,
  parameter int OUT_W  = 8
) (
  input  logic [DATA_W-1:0] x,
  input  logic [4:0]        sh,
  output logic [OUT_W-1:0]  y
);
  localparam logic signed [DATA_W-1:0] MAXV = DATA_W'((1 << (OUT_W-1)) - 1);
  localparam logic signed [DATA_W-1:0] MINV = -MAXV - DATA_W'(1);

  logic signed [DATA_W-1:0] shr, pre;

  // >>> fills with the sign bit, so oversized shifts settle at 0 or -1
  assign shr = $signed(x) >>> sh;

  always_comb begin
    pre = shr;
`ifdef OBUF_DRAIN_RELU_EN
    if (pre < 0) pre = '0;
`endif
    if (pre > MAXV)      y = MAXV[OUT_W-1:0];
    else if (pre < MINV) y = MINV[OUT_W-1:0];
    else                 y = pre[OUT_W-1:0];
  end
endmodule

module obuf_drain #(
  parameter int ARRAY_SIZE = 16,
  parameter int DATA_W     = 32,
  parameter int OUT_W      = 8
) (
  input  logic                                  clk,
  input  logic                                  nRST,
  input  logic [ARRAY_SIZE-1:0][DATA_W-1:0]     acc_sums,
  input  logic                                  capture,
  input  logic [4:0]                            shift_amt,
  output logic [ARRAY_SIZE-1:0]                 acc_clear,
  output logic                                  busy,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [OUT_W-1:0]                      out_data,
  output logic [$clog2(ARRAY_SIZE)-1:0]         out_col,
  output logic                                  out_last,
  output logic                                  overrun
);
  localparam int IDX_W = $clog2(ARRAY_SIZE);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                            state, state_n;
  logic [ARRAY_SIZE-1:0][DATA_W-1:0] shadow;
  logic [4:0]                        shift_q;
  logic [IDX_W-1:0]                  idx, idx_n;
  logic                              hs, last_hs, cap_acc, cap_drop;

  assign out_valid = (state == DRAIN);
  assign busy      = out_valid;
  assign out_col   = idx;
  assign out_last  = out_valid && (idx == IDX_W'(ARRAY_SIZE-1));
  assign hs        = out_valid & out_ready;
  assign last_hs   = hs & out_last;
  assign cap_acc   = capture & ((state == IDLE) | last_hs);
  assign cap_drop  = capture & (state == DRAIN) & ~last_hs;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      IDLE:  if (cap_acc) state_n = DRAIN;
      DRAIN: if (last_hs && !cap_acc) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (cap_acc)  idx_n = '0;
    else if (hs)  idx_n = out_last ? '0 : idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state     <= IDLE;
      idx       <= '0;
      shadow    <= '0;
      shift_q   <= '0;
      acc_clear <= '0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      acc_clear <= {ARRAY_SIZE{cap_acc}};
      if (cap_acc) begin
        shadow  <= acc_sums;
        shift_q <= shift_amt;
      end
      if (cap_drop) overrun <= 1'b1;
    end
  end

  obuf_requant #(.DATA_W(DATA_W), .OUT_W(OUT_W)) u_rq (
    .x (shadow[idx]),
    .sh(shift_q),
    .y (out_data)
  );
endmodule

// File: tb/tb_obuf_drain.sv
// Directed bench for obuf_drain: drain timing, requant/saturation, backpressure,
// overrun and back-to-back capture, mid-drain reset.
module tb_obuf_drain;
  logic                clk = 1'b0;
  logic                nRST;
  logic [15:0][31:0]   acc_sums;
  logic                capture;
  logic [4:0]          shift_amt;
  logic [15:0]         acc_clear;
  logic                busy, out_valid, out_ready, out_last, overrun;
  logic signed [7:0]   out_data;
  logic [3:0]          out_col;

  int checks = 0;
  int failures = 0;

  obuf_drain dut (
    .clk(clk), .nRST(nRST), .acc_sums(acc_sums), .capture(capture),
    .shift_amt(shift_amt), .acc_clear(acc_clear), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_col(out_col), .out_last(out_last), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [33:0] obs,
                       input logic signed [33:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_capture(input logic [4:0] sh);
    capture   = 1'b1;
    shift_amt = sh;
    tick();
    capture   = 1'b0;
  endtask

  task automatic drain_out();
    for (int i = 0; i < 40 && busy; i++) tick();
    check("drain_done", busy, 0);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_clr"}, acc_clear, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_vld"}, out_valid, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_col"}, out_col, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_ovr"}, overrun, 0);
  endtask

  initial begin
    int exp_w, got, k;
    logic [3:0] pat;
    nRST = 1'b0; capture = 1'b0; shift_amt = '0; out_ready = 1'b1; acc_sums = '0;
    tick(); tick();
    check_reset_outs("rst");
    nRST = 1'b1;

    // ramp c*256 >> 4 = c*16, saturating at 127 from col 8
    for (int c = 0; c < 16; c++) acc_sums[c] = 32'(c * 256);
    do_capture(5'd4);
    for (int c = 0; c < 16; c++) begin
      check("ramp_vld", out_valid, 1);
      check("ramp_busy", busy, 1);
      check("ramp_col", out_col, c);
      check("ramp_data", out_data, (c * 16 > 127) ? 127 : c * 16);
      check("ramp_last", out_last, (c == 15) ? 1 : 0);
      check("ramp_clr", acc_clear, (c == 0) ? 16'hFFFF : 16'h0);
      tick();
    end
    check("ramp_busy_end", busy, 0);
    check("ramp_vld_end", out_valid, 0);

    // signed saturation / ReLU
    acc_sums = '0;
    acc_sums[0] = -32'sd1000;
    acc_sums[1] = -32'sd5;
    acc_sums[2] = 32'h7FFF_FFFF;
    do_capture(5'd0);
`ifdef OBUF_DRAIN_RELU_EN
    check("sat_c0", out_data, 0); tick();
    check("sat_c1", out_data, 0); tick();
`else
    check("sat_c0", out_data, -128); tick();
    check("sat_c1", out_data, -5); tick();
`endif
    check("sat_c2", out_data, 127);
    drain_out();

    // backpressure with ready pattern 1,0,0,1
    for (int c = 0; c < 16; c++) acc_sums[c] = 32'(c + 10);
    pat = 4'b1001;
    do_capture(5'd0);
    exp_w = 0; got = 0; k = 0;
    while (exp_w < 16 && k < 100) begin
      out_ready = pat[3 - (k % 4)];
      check("bp_vld", out_valid, 1);
      check("bp_col", out_col, exp_w);
      check("bp_data", out_data, exp_w + 10);
      tick();
      if (out_ready) begin exp_w++; got++; end
      k++;
    end
    check("bp_words", got, 16);
    check("bp_busy_end", busy, 0);
    out_ready = 1'b1;

    // dropped capture at col 5, then capture on the last handshake
    for (int c = 0; c < 16; c++) acc_sums[c] = 32'(c * 2);
    do_capture(5'd1);
    for (int i = 0; i < 5; i++) tick();
    check("ovr_col5", out_col, 5);
    for (int c = 0; c < 16; c++) acc_sums[c] = 32'(c + 100);
    do_capture(5'd0);
    check("ovr_flag", overrun, 1);
    check("ovr_noclr", acc_clear, 0);
    check("ovr_col6", out_col, 6);
    check("ovr_data6", out_data, 6);
    for (int i = 0; i < 9; i++) tick();
    check("b2b_last", out_last, 1);
    check("b2b_data15", out_data, 15);
    do_capture(5'd0);
    check("b2b_busy", busy, 1);
    check("b2b_col0", out_col, 0);
    check("b2b_data0", out_data, 100);
    check("b2b_clr", acc_clear, 16'hFFFF);
    check("b2b_ovr_sticky", overrun, 1);
    shift_amt = 5'd3;
    tick();
    check("shift_hold", out_data, 101);
    drain_out();

    // max shift
    acc_sums = '0;
    acc_sums[0] = -32'sd7;
    acc_sums[1] = 32'sd7;
    do_capture(5'd31);
`ifdef OBUF_DRAIN_RELU_EN
    check("sh31_neg", out_data, 0);
`else
    check("sh31_neg", out_data, -1);
`endif
    tick();
    check("sh31_pos", out_data, 0);
    drain_out();

    // reset mid-drain
    for (int c = 0; c < 16; c++) acc_sums[c] = 32'(c * 2);
    do_capture(5'd1);
    for (int i = 0; i < 7; i++) tick();
    check("mrst_col7", out_col, 7);
    nRST = 1'b0;
    tick();
    check_reset_outs("mrst");
    nRST = 1'b1;
    for (int c = 0; c < 16; c++) acc_sums[c] = 32'(c * 3);
    do_capture(5'd0);
    check("post_clr", acc_clear, 16'hFFFF);
    check("post_col0", out_col, 0);
    check("post_data0", out_data, 0);
    for (int i = 0; i < 15; i++) tick();
    check("post_col15", out_col, 15);
    check("post_data15", out_data, 45);
    check("post_last", out_last, 1);
    drain_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
